// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory bus bundle
// for the data-memory access controller.
interface dmem_access_ctrl_if;
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [63:0] rdata;
   logic        done;
   logic        err;
   logic        busy;
   logic [63:0] mem_raddress;
   logic [63:0] mem_waddress;
   logic [63:0] mem_datain;
   logic        mem_wr;
   logic [63:0] mem_dataout;

   modport slave (
      input  req, we, funct3, addr, wdata,
      input  mem_dataout,
      output rdata, done, err, busy,
      output mem_raddress, mem_waddress,
      output mem_datain, mem_wr
   );

   modport master (
      output req, we, funct3, addr, wdata,
      output mem_dataout,
      input  rdata, done, err, busy,
      input  mem_raddress, mem_waddress,
      input  mem_datain, mem_wr
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory responder: aligned loads with extension,
// read-modify-write sub-doubleword stores.
module dmem_access_ctrl #(
   parameter int MEM_RD_LAT = 1
) (
   input logic Clk,
   input logic Reset,
   dmem_access_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, RD_WAIT, WRITE, RESP
   } state_t;

   state_t state, state_nx;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        err_q;
   logic [2:0]  cnt;
   logic [63:0] rdata_q;
   logic [63:0] raddr_q;
   logic [63:0] waddr_q;
   logic [63:0] wdat_q;

   logic        mis;
   logic        bad_f3;
   logic        illegal;
   logic        is_sd;
   logic        last;
   logic [5:0]  sh;
   logic [63:0] lane;
   logic [63:0] load_val;
   logic [63:0] size_m;
   logic [63:0] byte_m;
   logic [63:0] merged;

   always_comb begin
      mis = 1'b0;
      unique case (bus.funct3[1:0])
         2'd0: mis = 1'b0;
         2'd1: mis = bus.addr[0];
         2'd2: mis = |bus.addr[1:0];
         2'd3: mis = |bus.addr[2:0];
      endcase
      bad_f3 = bus.we ? bus.funct3[2]
                      : (bus.funct3 == 3'd7);
      illegal = mis | bad_f3;
      is_sd = bus.we & (bus.funct3 == 3'd3);
   end

   assign last = (cnt == 3'(MEM_RD_LAT - 1));
   assign sh   = {addr_q[2:0], 3'b000};
   assign lane = bus.mem_dataout >> sh;

   always_comb begin
      load_val = lane;
      unique case (f3_q)
         3'd0: load_val = {{56{lane[7]}}, lane[7:0]};
         3'd1: load_val = {{48{lane[15]}}, lane[15:0]};
         3'd2: load_val = {{32{lane[31]}}, lane[31:0]};
         3'd4: load_val = {56'd0, lane[7:0]};
         3'd5: load_val = {48'd0, lane[15:0]};
         3'd6: load_val = {32'd0, lane[31:0]};
         default: load_val = lane;
      endcase
   end

   // Lanes outside the store size keep the old memory bytes.
   always_comb begin
      size_m = '1;
      unique case (f3_q[1:0])
         2'd0: size_m = 64'h0000_0000_0000_00ff;
         2'd1: size_m = 64'h0000_0000_0000_ffff;
         2'd2: size_m = 64'h0000_0000_ffff_ffff;
         2'd3: size_m = '1;
      endcase
      byte_m = size_m << sh;
      merged = (bus.mem_dataout & ~byte_m)
             | ((wdata_q << sh) & byte_m);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (bus.req) begin
               if (illegal)    state_nx = RESP;
               else if (is_sd) state_nx = WRITE;
               else            state_nx = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (last)
               state_nx = we_q ? WRITE : RESP;
         end
         WRITE:   state_nx = RESP;
         RESP:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         cnt     <= '0;
         rdata_q <= '0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdat_q  <= '0;
      end else begin
         if (state == IDLE && bus.req) begin
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            err_q   <= illegal;
            cnt     <= '0;
            if (!illegal) begin
               if (is_sd) begin
                  waddr_q <= {bus.addr[63:3], 3'b000};
                  wdat_q  <= bus.wdata;
               end else begin
                  raddr_q <= {bus.addr[63:3], 3'b000};
               end
            end
         end
         if (state == RD_WAIT) begin
            cnt <= cnt + 3'd1;
            if (last) begin
               if (we_q) begin
                  waddr_q <= {addr_q[63:3], 3'b000};
                  wdat_q  <= merged;
               end else begin
                  rdata_q <= load_val;
               end
            end
         end
      end
   end

   assign bus.done         = (state == RESP);
   assign bus.err          = (state == RESP) & err_q;
   assign bus.busy         = (state != IDLE);
   assign bus.mem_wr       = (state == WRITE);
   assign bus.rdata        = rdata_q;
   assign bus.mem_raddress = raddr_q;
   assign bus.mem_waddress = waddr_q;
   assign bus.mem_datain   = wdat_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table with
// scoreboard, plus reset/busy/latency sequences.
module tb_dmem_access_ctrl;

   logic Clk;
   logic Reset;
   logic ld;

   dmem_access_ctrl_if b1 ();
   dmem_access_ctrl_if b3 ();

   dmem_access_ctrl #(.MEM_RD_LAT(1)) u1 (
      .Clk(Clk), .Reset(Reset), .bus(b1)
   );
   dmem_access_ctrl #(.MEM_RD_LAT(3)) u3 (
      .Clk(Clk), .Reset(Reset), .bus(b3)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [63:0] mem1 [8];
   logic [63:0] mem3 [8];
   logic [63:0] p0, p1;
   int          wr_cnt;
   logic [63:0] last_wa, last_wd;

   always @(posedge Clk) begin
      if (ld) begin
         for (int i = 0; i < 8; i++) begin
            mem1[i] <= 64'd0;
            mem3[i] <= 64'd0;
         end
         mem1[2] <= 64'h8877665544332211;
         mem3[2] <= 64'h8877665544332211;
      end else begin
         if (b1.mem_wr)
            mem1[b1.mem_waddress[5:3]] <= b1.mem_datain;
         if (b3.mem_wr)
            mem3[b3.mem_waddress[5:3]] <= b3.mem_datain;
      end
   end

   always @(posedge Clk) begin
      if (ld) begin
         wr_cnt  <= 0;
         last_wa <= '0;
         last_wd <= '0;
      end else if (b1.mem_wr) begin
         wr_cnt  <= wr_cnt + 1;
         last_wa <= b1.mem_waddress;
         last_wd <= b1.mem_datain;
      end
   end

   assign b1.mem_dataout = mem1[b1.mem_raddress[5:3]];

   always @(posedge Clk) begin
      p0 <= mem3[b3.mem_raddress[5:3]];
      p1 <= p0;
   end
   assign b3.mem_dataout = p1;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          wr;
      logic [63:0] wa;
      logic [63:0] wd;
   } vec_t;

   vec_t tbl [20];
   vec_t sbq [$];
   int   passed;
   int   total;

   function automatic vec_t mk(
      input logic we, input logic [2:0] f3,
      input logic [63:0] addr, input logic [63:0] wdata,
      input logic [63:0] rdata, input logic err,
      input int lat, input int wr,
      input logic [63:0] wa, input logic [63:0] wd);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.err = err;
      v.lat = lat; v.wr = wr; v.wa = wa; v.wd = wd;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h",
                    nm, act, exp);
   endtask

   task automatic drive1(input vec_t v);
      b1.req = 1'b1; b1.we = v.we;
      b1.funct3 = v.f3; b1.addr = v.addr;
      b1.wdata = v.wdata;
   endtask

   // Called at a negedge; returns at the negedge after done.
   task automatic run(input vec_t v, input string nm);
      vec_t e;
      int   lat;
      int   w0;
      bit   got;
      w0 = wr_cnt;
      drive1(v);
      sbq.push_back(v);
      lat = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge Clk);
         lat++;
         @(negedge Clk);
         b1.req = 1'b0;
         if (i == 0) chk({nm, "_busy"}, b1.busy, 1);
         if (b1.done) got = 1;
      end
      e = sbq.pop_front();
      chk({nm, "_done"}, got, 1);
      chk({nm, "_lat"}, lat, e.lat);
      chk({nm, "_err"}, b1.err, e.err);
      chk({nm, "_rdata"}, b1.rdata, e.rdata);
      chk({nm, "_wrs"}, wr_cnt - w0, e.wr);
      if (e.wr != 0) begin
         chk({nm, "_waddr"}, last_wa, e.wa);
         chk({nm, "_wdata"}, last_wd, e.wd);
      end
      @(negedge Clk);
      chk({nm, "_pulse"}, b1.done, 0);
      chk({nm, "_idle"}, b1.busy, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int   lat;
      int   w0;
      bit   got;
      vec_t e;

      passed = 0;
      total  = 0;
      Reset  = 1'b1;
      ld     = 1'b1;
      b1.req = 0; b1.we = 0; b1.funct3 = 0;
      b1.addr = 0; b1.wdata = 0;
      b3.req = 0; b3.we = 0; b3.funct3 = 0;
      b3.addr = 0; b3.wdata = 0;

      tbl[0]  = mk(0, 0, 'h17, 0, 64'hFFFFFFFFFFFFFF88, 0, 2, 0, 0, 0);
      tbl[1]  = mk(0, 5, 'h16, 0, 64'h8877, 0, 2, 0, 0, 0);
      tbl[2]  = mk(0, 2, 'h10, 0, 64'h44332211, 0, 2, 0, 0, 0);
      tbl[3]  = mk(1, 0, 'h11, 'hAB, 64'h44332211, 0, 3, 1,
                   'h10, 64'h887766554433AB11);
      tbl[4]  = mk(1, 3, 'h18, 64'h0123456789ABCDEF, 64'h44332211,
                   0, 2, 1, 'h18, 64'h0123456789ABCDEF);
      tbl[5]  = mk(0, 3, 'h18, 0, 64'h0123456789ABCDEF, 0, 2, 0, 0, 0);
      tbl[6]  = mk(0, 2, 'h12, 0, 64'h0123456789ABCDEF, 1, 1, 0, 0, 0);
      tbl[7]  = mk(1, 5, 'h10, 'h55, 64'h0123456789ABCDEF, 1, 1, 0, 0, 0);
      tbl[8]  = mk(0, 1, 'h16, 0, 64'hFFFFFFFFFFFF8877, 0, 2, 0, 0, 0);
      tbl[9]  = mk(0, 6, 'h14, 0, 64'h88776655, 0, 2, 0, 0, 0);
      tbl[10] = mk(0, 0, 'h11, 0, 64'hFFFFFFFFFFFFFFAB, 0, 2, 0, 0, 0);
      tbl[11] = mk(0, 4, 'h11, 0, 64'hAB, 0, 2, 0, 0, 0);
      tbl[12] = mk(1, 1, 'h1E, 64'h1111BEEF, 64'hAB, 0, 3, 1,
                   'h18, 64'hBEEF456789ABCDEF);
      tbl[13] = mk(1, 2, 'h1C, 64'hFFFFFFFFCAFEF00D, 64'hAB, 0, 3, 1,
                   'h18, 64'hCAFEF00D89ABCDEF);
      tbl[14] = mk(0, 3, 'h18, 0, 64'hCAFEF00D89ABCDEF, 0, 2, 0, 0, 0);
      tbl[15] = mk(0, 2, 'h1C, 0, 64'hFFFFFFFFCAFEF00D, 0, 2, 0, 0, 0);
      tbl[16] = mk(1, 3, 'h14, 'h1, 64'hFFFFFFFFCAFEF00D, 1, 1, 0, 0, 0);
      tbl[17] = mk(0, 3, 'h1C, 0, 64'hFFFFFFFFCAFEF00D, 1, 1, 0, 0, 0);
      tbl[18] = mk(0, 7, 'h10, 0, 64'hFFFFFFFFCAFEF00D, 1, 1, 0, 0, 0);
      tbl[19] = mk(0, 1, 'h11, 0, 64'hFFFFFFFFCAFEF00D, 1, 1, 0, 0, 0);

      repeat (3) @(negedge Clk);
      chk("rst_rdata", b1.rdata, 0);
      chk("rst_done", b1.done, 0);
      chk("rst_err", b1.err, 0);
      chk("rst_busy", b1.busy, 0);
      chk("rst_wr", b1.mem_wr, 0);
      chk("rst_raddr", b1.mem_raddress, 0);
      chk("rst_waddr", b1.mem_waddress, 0);
      chk("rst_datain", b1.mem_datain, 0);
      Reset = 1'b0;
      ld    = 1'b0;
      @(negedge Clk);

      for (int i = 0; i < 20; i++) begin
         run(tbl[i], $sformatf("v%0d", i));
         if (i == 0) chk("v0_raddr", b1.mem_raddress, 'h10);
      end

      // Request held while busy must not start a second access.
      w0 = wr_cnt;
      drive1(mk(0, 0, 'h17, 0, 0, 0, 2, 0, 0, 0));
      sbq.push_back(mk(0, 0, 'h17, 0,
                       64'hFFFFFFFFFFFFFF88, 0, 2, 0, 0, 0));
      @(posedge Clk);
      @(negedge Clk);
      drive1(mk(1, 3, 'h20, 64'hDEADBEEFDEADBEEF, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      @(negedge Clk);
      e = sbq.pop_front();
      chk("bsy_done", b1.done, 1);
      chk("bsy_rdata", b1.rdata, e.rdata);
      @(posedge Clk);
      @(negedge Clk);
      b1.req = 1'b0;
      chk("bsy_idle", b1.busy, 0);
      repeat (3) @(negedge Clk);
      chk("bsy_idle2", b1.busy, 0);
      chk("bsy_nowr", wr_cnt - w0, 0);
      chk("bsy_mem", mem1[4], 0);

      // Reset during the read phase of a halfword store.
      w0 = wr_cnt;
      drive1(mk(1, 1, 'h14, 64'h7777, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      @(negedge Clk);
      b1.req = 1'b0;
      chk("mrs_busy", b1.busy, 1);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      chk("mrs_busy0", b1.busy, 0);
      chk("mrs_done", b1.done, 0);
      chk("mrs_err", b1.err, 0);
      chk("mrs_wr", b1.mem_wr, 0);
      chk("mrs_rdata", b1.rdata, 0);
      chk("mrs_raddr", b1.mem_raddress, 0);
      chk("mrs_waddr", b1.mem_waddress, 0);
      chk("mrs_datain", b1.mem_datain, 0);
      repeat (4) @(negedge Clk);
      chk("mrs_nowr", wr_cnt - w0, 0);
      chk("mrs_mem", mem1[2], 64'h887766554433AB11);

      // Request and reset on the same edge: reset wins.
      drive1(mk(0, 3, 'h10, 0, 0, 0, 0, 0, 0, 0));
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset  = 1'b0;
      b1.req = 1'b0;
      chk("rr_busy", b1.busy, 0);
      @(negedge Clk);
      chk("rr_busy2", b1.busy, 0);
      chk("rr_rdata", b1.rdata, 0);

      run(mk(0, 0, 'h10, 0, 64'h11, 0, 2, 0, 0, 0), "post");

      // Longer memory latency on the second instance.
      b3.req = 1'b1; b3.we = 1'b0;
      b3.funct3 = 3'd0; b3.addr = 'h17;
      lat = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge Clk);
         lat++;
         @(negedge Clk);
         b3.req = 1'b0;
         if (b3.done) got = 1;
      end
      chk("l3_done", got, 1);
      chk("l3_lat", lat, 4);
      chk("l3_err", b3.err, 0);
      chk("l3_rdata", b3.rdata, 64'hFFFFFFFFFFFFFF88);
      chk("l3_raddr", b3.mem_raddress, 'h10);
      @(negedge Clk);
      chk("l3_pulse", b3.done, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
